// File: rtl/tdc_meas_sequencer.sv
// rtl/tdc_meas_sequencer.sv - burst sequencer for single-shot TDC measurements with byte-stream result output
//
// Purpose:
//   Runs a burst of 1..16 TDC shots. Each shot clears the TDC, counts coarse
//   clock cycles until a stop rising edge (or a coarse timeout), collects the
//   fine interpolator code (or times out waiting for it), then streams a
//   4-byte result frame over a valid/ready byte interface. eot pulses once
//   when the whole burst has been sent.
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous, active-high
//   arm         start-burst request, only looked at while idle
//   burst_len   shots per burst, latched on arm (0 selects 16)
//   stop        synchronised stop event; its rising edge ends a shot
//   fine_code   fine interpolator code
//   fine_valid  single-cycle strobe qualifying fine_code
//   tdc_clear   one-cycle clear pulse to the TDC core
//   tx_data     result byte
//   tx_valid    tx_data valid
//   tx_ready    byte accepted when high together with tx_valid
//   busy        high whenever not idle
//   eot         one-cycle end-of-burst pulse
//
// Frame layout: {timeout, 3'b000, index}, coarse[15:8], coarse[7:0], fine.

module tdc_meas_sequencer #(
    parameter logic [15:0] TIMEOUT_CYC = 16'hFFFF,
    parameter int unsigned FINE_WAIT   = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       arm,
    input  logic [3:0] burst_len,
    input  logic       stop,
    input  logic [7:0] fine_code,
    input  logic       fine_valid,
    output logic       tdc_clear,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic       eot
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_CLEAR     = 3'd1,
        S_RUN       = 3'd2,
        S_WAIT_FINE = 3'd3,
        S_SEND      = 3'd4,
        S_DONE      = 3'd5
    } state_t;

    localparam logic [15:0] COARSE_LAST = TIMEOUT_CYC - 16'd1;
    localparam logic [7:0]  FINE_LAST   = 8'(FINE_WAIT - 1);

    state_t      state_q, state_d;
    logic        stop_dly_q, stop_dly_d;
    logic [15:0] coarse_q, coarse_d;
    logic [15:0] coarse_cap_q, coarse_cap_d;
    logic [7:0]  fine_cap_q, fine_cap_d;
    logic        timeout_q, timeout_d;
    logic [3:0]  index_q, index_d;
    logic [4:0]  remaining_q, remaining_d;
    logic [7:0]  fine_cnt_q, fine_cnt_d;
    logic [1:0]  byte_q, byte_d;
    logic        tx_valid_q, tx_valid_d;
    logic [7:0]  tx_data_q, tx_data_d;

    logic        stop_edge;
    logic        coarse_expired;
    logic        fine_expired;
    logic        tx_fire;
    logic        last_byte;
    logic [1:0]  byte_sel;
    logic [7:0]  frame_byte;

    always_comb begin
        stop_edge      = stop & ~stop_dly_q;
        coarse_expired = (coarse_q == COARSE_LAST);
        fine_expired   = (fine_cnt_q == FINE_LAST);
        tx_fire        = tx_valid_q & tx_ready;
        last_byte      = (byte_q == 2'd3);
    end

    // Byte to present next: the current index when nothing is on the bus yet
    // (first byte of the frame), otherwise the one after the byte now on the bus.
    always_comb begin
        byte_sel = tx_valid_q ? (byte_q + 2'd1) : byte_q;
        case (byte_sel)
            2'd0:    frame_byte = {timeout_q, 3'b000, index_q};
            2'd1:    frame_byte = coarse_cap_q[15:8];
            2'd2:    frame_byte = coarse_cap_q[7:0];
            default: frame_byte = fine_cap_q;
        endcase
    end

    // State register and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            stop_dly_q   <= 1'b0;
            coarse_q     <= 16'd0;
            coarse_cap_q <= 16'd0;
            fine_cap_q   <= 8'd0;
            timeout_q    <= 1'b0;
            index_q      <= 4'd0;
            remaining_q  <= 5'd0;
            fine_cnt_q   <= 8'd0;
            byte_q       <= 2'd0;
            tx_valid_q   <= 1'b0;
            tx_data_q    <= 8'h00;
        end else begin
            state_q      <= state_d;
            stop_dly_q   <= stop_dly_d;
            coarse_q     <= coarse_d;
            coarse_cap_q <= coarse_cap_d;
            fine_cap_q   <= fine_cap_d;
            timeout_q    <= timeout_d;
            index_q      <= index_d;
            remaining_q  <= remaining_d;
            fine_cnt_q   <= fine_cnt_d;
            byte_q       <= byte_d;
            tx_valid_q   <= tx_valid_d;
            tx_data_q    <= tx_data_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (arm) begin
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                // A stop edge in the timeout cycle still counts as a measurement.
                if (stop_edge) begin
                    state_d = S_WAIT_FINE;
                end else if (coarse_expired) begin
                    state_d = S_SEND;
                end
            end
            S_WAIT_FINE: begin
                if (fine_valid || fine_expired) begin
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (tx_fire && last_byte) begin
                    state_d = (remaining_q > 5'd1) ? S_CLEAR : S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Datapath next values
    always_comb begin
        stop_dly_d   = stop;
        coarse_d     = coarse_q;
        coarse_cap_d = coarse_cap_q;
        fine_cap_d   = fine_cap_q;
        timeout_d    = timeout_q;
        index_d      = index_q;
        remaining_d  = remaining_q;
        fine_cnt_d   = fine_cnt_q;
        byte_d       = byte_q;
        tx_valid_d   = tx_valid_q;
        tx_data_d    = tx_data_q;

        case (state_q)
            S_IDLE: begin
                if (arm) begin
                    remaining_d = (burst_len == 4'd0) ? 5'd16 : {1'b0, burst_len};
                    index_d     = 4'd0;
                end
            end
            S_CLEAR: begin
                coarse_d = 16'd0;
                byte_d   = 2'd0;
            end
            S_RUN: begin
                coarse_d   = coarse_q + 16'd1;
                fine_cnt_d = 8'd0;
                if (stop_edge) begin
                    coarse_cap_d = coarse_q;
                    timeout_d    = 1'b0;
                end else if (coarse_expired) begin
                    coarse_cap_d = 16'hFFFF;
                    fine_cap_d   = 8'hFF;
                    timeout_d    = 1'b1;
                end
            end
            S_WAIT_FINE: begin
                if (fine_valid) begin
                    fine_cap_d = fine_code;
                end else if (fine_expired) begin
                    fine_cap_d = 8'hFF;
                    timeout_d  = 1'b1;
                end else begin
                    fine_cnt_d = fine_cnt_q + 8'd1;
                end
            end
            S_SEND: begin
                // tx_valid is low only in the first SEND cycle, so raising it
                // here puts byte 0 on the bus one cycle after SEND entry.
                if (!tx_valid_q) begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = frame_byte;
                end else if (tx_fire) begin
                    if (last_byte) begin
                        tx_valid_d  = 1'b0;
                        index_d     = index_q + 4'd1;
                        remaining_d = remaining_q - 5'd1;
                    end else begin
                        byte_d    = byte_q + 2'd1;
                        tx_data_d = frame_byte;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    // Outputs
    always_comb begin
        tdc_clear = (state_q == S_CLEAR);
        busy      = (state_q != S_IDLE);
        eot       = (state_q == S_DONE);
        tx_valid  = tx_valid_q;
        tx_data   = tx_data_q;
    end

endmodule

// File: doc/tdc_meas_sequencer.md
Name: tdc_meas_sequencer

Overview:
Controller that sequences the TDC core through bursts of single-shot measurements. Per shot it clears the TDC, runs a coarse cycle counter until the stop edge or a timeout, then collects the fine delay-line code. It packs each result into a 4-byte frame, streams the frame to the UART transmitter over a valid/ready handshake, and pulses eot when the burst completes.

Parameters:
TIMEOUT_CYC, 16'hFFFF, coarse count at which a shot is abandoned as a timeout (range 2..65535).
FINE_WAIT, 8, cycles allowed in WAIT_FINE for fine_valid before the fine code is forced to 8'hFF.

Ports:
clk  input  1  system clock, all logic rising-edge.
reset  input  1  asynchronous, active-high; clears all state.
arm  input  1  start-burst request, sampled in IDLE only.
burst_len  input  4  shots per burst, latched on arm; 0 means 16.
stop  input  1  TDC stop event, already synchronised to clk; rising edge ends a shot.
fine_code  input  8  fine interpolator code from the TDC.
fine_valid  input  1  fine_code valid strobe (single-cycle).
tdc_clear  output  1  one-cycle clear pulse to the TDC core.
tx_data  output  8  byte to UART.
tx_valid  output  1  tx_data valid.
tx_ready  input  1  UART accepts the byte this cycle.
busy  output  1  high in every state except IDLE.
eot  output  1  one-cycle end-of-burst pulse.

Behaviour:
- Reset values: state IDLE; tdc_clear, tx_valid, busy, eot = 0; tx_data = 8'h00; coarse, shot index, remaining and stop_d = 0.
- stop_d <= stop every cycle in all states. Edge = stop & ~stop_d.
- IDLE: arm=1 -> CLEAR. Latch remaining = (burst_len==0 ? 16 : burst_len). Set index = 0.
- CLEAR (1 cycle): tdc_clear=1 and coarse <= 0 -> RUN.
- RUN: coarse increments by 1 each cycle.
  - Edge seen: capture coarse value as of that cycle, timeout bit=0 -> WAIT_FINE.
  - No edge and coarse == TIMEOUT_CYC-1: coarse_cap=16'hFFFF, fine_cap=8'hFF, timeout bit=1 -> SEND.
  - Edge and timeout in the same cycle: the edge wins.
  - A stop already high on RUN entry gives no edge and is not a measurement.
- WAIT_FINE: on fine_valid, capture fine_code -> SEND. If FINE_WAIT cycles pass with no fine_valid: fine_cap=8'hFF, timeout bit=1 -> SEND. fine_valid outside WAIT_FINE is ignored.
- SEND: transmit 4 bytes, in order:
  - B0 = {timeout, 3'b000, index[3:0]}
  - B1 = coarse_cap[15:8]
  - B2 = coarse_cap[7:0]
  - B3 = fine_cap
- Handshake:
  - tx_valid rises the cycle after SEND entry.
  - tx_data stays stable while tx_valid=1 and tx_ready=0.
  - A byte transfers on tx_valid & tx_ready. The next byte is presented the following cycle, so tx_valid may stay high back-to-back.
  - tx_ready while tx_valid=0 has no effect.
- After B3 transfers: tx_valid=0, index+1, remaining-1. If remaining was >1 -> CLEAR, else -> DONE.
- DONE (1 cycle): eot=1 -> IDLE.
- Ignored inputs: arm outside IDLE, and stop edges outside RUN.
- Async reset mid-burst: returns to IDLE within the reset assertion, with no partial frame resumed. Any byte in flight is abandoned, since tx_valid is forced to 0.
- Latency, shot with stop edge at RUN cycle k and fine_valid d cycles later: first tx_valid is 2+d cycles after the edge. Frame takes at least 4 cycles.

Test Plan:
- Reset, then arm, burst_len=1, stop edge when coarse=0x0123, fine_valid with fine_code=0x5A one cycle later, tx_ready always 1. Required: one tdc_clear pulse; bytes 0x00,0x01,0x23,0x5A; eot one cycle after the last transfer; busy falls with eot.
- Same shot with tx_ready low for 3 cycles on each byte. Required: tx_data held constant while stalled; same 4 bytes; no drops or duplicates.
- TIMEOUT_CYC=16, no stop. Required: frame 0x80,0xFF,0xFF,0xFF; eot follows.
- burst_len=0 with a stop edge every shot. Required: 16 frames with B0 = 0x00..0x0F; 16 tdc_clear pulses; exactly one eot.
- stop held high through CLEAR, dropped, then re-raised at coarse=5. Required: no capture at RUN entry; B2=0x05. Also no fine_valid for FINE_WAIT cycles. Required: B0 bit7=1, B3=0xFF.
- Assert reset during SEND after B1 transfers. Required: tx_valid=0 and busy=0 immediately. A later arm starts a fresh frame with B0 index 0.
